// File: rtl/adder_join_pkg.sv
// adder_join_pkg: shared FSM state type and sum-width helper for the N-input join adder
// Contents: join_state_t (S_IDLE/S_SEND/S_ACK), sum_width(width, n) = width + clog2(n)
package adder_join_pkg;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_ACK} join_state_t;

    function automatic int sum_width(input int width, input int n);
        return width + $clog2(n);
    endfunction

endpackage

// File: rtl/adder_tree_n.sv
// adder_tree_n: combinational zero-extended unsigned sum of N packed WIDTH-bit operands
// Ports: ldata [N*WIDTH] operands (channel i at [i*WIDTH +: WIDTH]), sum [SW] full-precision sum
module adder_tree_n
    import adder_join_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int N     = 2,
    parameter int SW    = sum_width(WIDTH, N)
) (
    input  logic [N*WIDTH-1:0] ldata,
    output logic [SW-1:0]      sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++)
            sum = sum + {{(SW-WIDTH){1'b0}}, ldata[i*WIDTH +: WIDTH]};
    end

endmodule

// File: rtl/adder_join_n.sv
// adder_join_n: N-channel 4-phase join adder with wrap/saturate result and registered sum
// Ports: clk, rst_n (async active-low), lreq/lack [N] input handshakes, ldata [N*WIDTH] operands,
//        rreq/rack output handshake, rdata [WIDTH] registered sum,
//        ovf (only when ADDER_JOIN_OVF_EN is defined) registered overflow of the wide sum
module adder_join_n
    import adder_join_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int N        = 2,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       lreq,
    output logic [N-1:0]       lack,
    input  logic [N*WIDTH-1:0] ldata,
    output logic               rreq,
    input  logic               rack,
    output logic [WIDTH-1:0]   rdata
`ifdef ADDER_JOIN_OVF_EN
    ,
    output logic               ovf
`endif
);

    localparam int SW = sum_width(WIDTH, N);

    join_state_t      state;
    logic [SW-1:0]    sum;
    logic             over;
    logic [WIDTH-1:0] res;

    adder_tree_n #(.WIDTH(WIDTH), .N(N), .SW(SW)) u_tree (
        .ldata(ldata),
        .sum  (sum)
    );

    // any bit above WIDTH means the true sum does not fit in rdata
    assign over = |sum[SW-1:WIDTH];
    assign res  = (SATURATE != 0 && over) ? '1 : sum[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            rreq  <= 1'b0;
            lack  <= '0;
            rdata <= '0;
`ifdef ADDER_JOIN_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (&lreq) begin
                    rdata <= res;
`ifdef ADDER_JOIN_OVF_EN
                    ovf   <= over;
`endif
                    rreq  <= 1'b1;
                    state <= S_SEND;
                end
                S_SEND: if (rack) begin
                    rreq  <= 1'b0;
                    lack  <= '1;
                    state <= S_ACK;
                end
                S_ACK: if (!rack && lreq == '0) begin
                    lack  <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_join_n.sv
// tb_adder_join_n: scoreboard bench for adder_join_n (N=2 wrap/saturate pair and an N=4 WIDTH=8 instance)
module tb_adder_join_n;

    logic        clk = 0;
    logic        rst_n = 0;
    logic [1:0]  lreq2 = '0;
    logic [19:0] ldata2 = '0;
    logic        rack2 = 0;
    logic [1:0]  lack_w, lack_s;
    logic        rreq_w, rreq_s;
    logic [9:0]  rdata_w, rdata_s;
    logic        ovf_w, ovf_s, ovf_q;
    logic [3:0]  lreq4 = '0;
    logic [31:0] ldata4 = '0;
    logic        rack4 = 0;
    logic [3:0]  lack4;
    logic        rreq4;
    logic [7:0]  rdata4;

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_w[$], exp_s[$], exp_q[$];
    bit exp_o[$];

    always #5 clk = ~clk;

    adder_join_n #(.WIDTH(10), .N(2), .SATURATE(0)) u_w (
        .clk(clk), .rst_n(rst_n), .lreq(lreq2), .lack(lack_w), .ldata(ldata2),
        .rreq(rreq_w), .rack(rack2), .rdata(rdata_w)
`ifdef ADDER_JOIN_OVF_EN
        , .ovf(ovf_w)
`endif
    );

    adder_join_n #(.WIDTH(10), .N(2), .SATURATE(1)) u_s (
        .clk(clk), .rst_n(rst_n), .lreq(lreq2), .lack(lack_s), .ldata(ldata2),
        .rreq(rreq_s), .rack(rack2), .rdata(rdata_s)
`ifdef ADDER_JOIN_OVF_EN
        , .ovf(ovf_s)
`endif
    );

    adder_join_n #(.WIDTH(8), .N(4), .SATURATE(0)) u_q (
        .clk(clk), .rst_n(rst_n), .lreq(lreq4), .lack(lack4), .ldata(ldata4),
        .rreq(rreq4), .rack(rack4), .rdata(rdata4)
`ifdef ADDER_JOIN_OVF_EN
        , .ovf(ovf_q)
`endif
    );

`ifndef ADDER_JOIN_OVF_EN
    assign ovf_w = 1'b0;
    assign ovf_s = 1'b0;
    assign ovf_q = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 4-phase transaction on the N=2 pair; returns captured outputs, request latency and protocol health.
    task automatic run2(input logic [9:0] a, input logic [9:0] b,
                        output logic [9:0] gw, output logic [9:0] gs,
                        output logic ow, output logic os, output int lat, output bit ok);
        int n;
        ok = 1;
        ldata2 = {b, a};
        lreq2 = 2'b11;
        n = 0;
        do begin tick(); n++; end while (!(rreq_w && rreq_s) && n < 10);
        lat = n;
        if (!(rreq_w && rreq_s)) ok = 0;
        gw = rdata_w;
        gs = rdata_s;
        ow = ovf_w;
        os = ovf_s;
        rack2 = 1;
        n = 0;
        do begin tick(); n++; end while (!(lack_w == 2'b11 && lack_s == 2'b11) && n < 10);
        if (lack_w != 2'b11 || lack_s != 2'b11 || rreq_w || rreq_s) ok = 0;
        rack2 = 0;
        lreq2 = 2'b00;
        n = 0;
        do begin tick(); n++; end while (!(lack_w == 2'b00 && lack_s == 2'b00) && n < 10);
        if (lack_w != 2'b00 || lack_s != 2'b00) ok = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #3;
        total_cnt++;
        if ({rreq_w, lack_w, rdata_w, rreq_s, lack_s, rdata_s, ovf_w, ovf_s} !== '0)
            $display("FAIL reset_pair: got rreq=%b lack=%b rdata=%0d / %b %b %0d required all zero",
                     rreq_w, lack_w, rdata_w, rreq_s, lack_s, rdata_s);
        else pass_cnt++;
        total_cnt++;
        if ({rreq4, lack4, rdata4, ovf_q} !== '0)
            $display("FAIL reset_quad: got rreq=%b lack=%b rdata=%0d required 0 0 0", rreq4, lack4, rdata4);
        else pass_cnt++;
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_pair(input logic [9:0] a, input logic [9:0] b, input bit check_lat);
        logic [9:0] gw, gs;
        logic ow, os;
        int lat, wide, ew, es;
        bit ok, eo;
        wide = int'(a) + int'(b);
        exp_w.push_back(wide % 1024);
        exp_s.push_back(wide > 1023 ? 1023 : wide);
        exp_o.push_back(wide > 1023);
        run2(a, b, gw, gs, ow, os, lat, ok);
        ew = exp_w.pop_front();
        es = exp_s.pop_front();
        eo = exp_o.pop_front();
        total_cnt++;
        if (!ok) $display("FAIL handshake_%0d_%0d: protocol sequence did not complete, required full 4-phase", a, b);
        else pass_cnt++;
        total_cnt++;
        if (int'(gw) !== ew) $display("FAIL wrap_%0d_%0d: got %0d required %0d", a, b, gw, ew);
        else pass_cnt++;
        total_cnt++;
        if (int'(gs) !== es) $display("FAIL sat_%0d_%0d: got %0d required %0d", a, b, gs, es);
        else pass_cnt++;
`ifdef ADDER_JOIN_OVF_EN
        total_cnt++;
        if (ow !== eo || os !== eo) $display("FAIL ovf_%0d_%0d: got %b/%b required %b", a, b, ow, os, eo);
        else pass_cnt++;
`endif
        if (check_lat) begin
            total_cnt++;
            if (lat !== 1) $display("FAIL rreq_latency: got %0d edges required 1", lat);
            else pass_cnt++;
        end
    endtask

    task automatic test_rack_idle();
        rack4 = 1;
        tick();
        tick();
        total_cnt++;
        if (rreq4 !== 1'b0 || lack4 !== 4'b0000)
            $display("FAIL rack_idle: got rreq=%b lack=%b required 0 0000", rreq4, lack4);
        else pass_cnt++;
        rack4 = 0;
        tick();
    endtask

    task automatic test_join4();
        logic [7:0] vals [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        int bad;
        exp_q.push_back(100);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            ldata4[i*8 +: 8] = vals[i];
            lreq4[i] = 1'b1;
            tick();
            if (i < 3 && (rreq4 !== 1'b0 || lack4 !== 4'b0000)) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL join_partial: got %0d early responses required 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (rreq4 !== 1'b1) $display("FAIL join_rreq: got %b required 1", rreq4);
        else pass_cnt++;
        total_cnt++;
        if (int'(rdata4) !== exp_q[0]) $display("FAIL join_sum: got %0d required %0d", rdata4, exp_q[0]);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        int bad, e;
        e = exp_q.pop_front();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rreq4 !== 1'b1 || int'(rdata4) !== e || lack4 !== 4'b0000) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL hold_send: got %0d unstable cycles required 0", bad);
        else pass_cnt++;
        rack4 = 1;
        tick();
        total_cnt++;
        if (lack4 !== 4'b1111 || rreq4 !== 1'b0)
            $display("FAIL ack_rise: got lack=%b rreq=%b required 1111 0", lack4, rreq4);
        else pass_cnt++;
    endtask

    task automatic test_release();
        int bad;
        bad = 0;
        rack4 = 0;
        for (int i = 0; i < 3; i++) begin
            lreq4[i] = 1'b0;
            tick();
            if (lack4 !== 4'b1111) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL release_partial: got %0d early drops required 0", bad);
        else pass_cnt++;
        lreq4[3] = 1'b0;
        tick();
        total_cnt++;
        if (lack4 !== 4'b0000) $display("FAIL release_done: got %b required 0000", lack4);
        else pass_cnt++;
        total_cnt++;
        if (int'(rdata4) !== 100) $display("FAIL rdata_persist: got %0d required 100", rdata4);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n, e;
        ldata4 = {8'd0, 8'd0, 8'd6, 8'd5};
        lreq4 = 4'b1111;
        tick();
        total_cnt++;
        if (rreq4 !== 1'b1) $display("FAIL mid_setup: got rreq=%b required 1", rreq4);
        else pass_cnt++;
        #2 rst_n = 0;
        #1;
        total_cnt++;
        if (rreq4 !== 1'b0 || lack4 !== 4'b0000 || rdata4 !== 8'd0)
            $display("FAIL mid_reset: got rreq=%b lack=%b rdata=%0d required 0 0000 0", rreq4, lack4, rdata4);
        else pass_cnt++;
        lreq4 = 4'b0000;
        tick();
        rst_n = 1;
        tick();
        exp_q.push_back(11);
        lreq4 = 4'b1111;
        n = 0;
        do begin tick(); n++; end while (!rreq4 && n < 10);
        e = exp_q.pop_front();
        total_cnt++;
        if (!rreq4 || int'(rdata4) !== e) $display("FAIL post_reset_sum: got rreq=%b rdata=%0d required 1 %0d", rreq4, rdata4, e);
        else pass_cnt++;
        rack4 = 1;
        tick();
        rack4 = 0;
        lreq4 = 4'b0000;
        tick();
        total_cnt++;
        if (lack4 !== 4'b0000 || rreq4 !== 1'b0)
            $display("FAIL post_reset_done: got lack=%b rreq=%b required 0000 0", lack4, rreq4);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_pair(10'd123, 10'd456, 1);
        test_pair(10'd800, 10'd100, 0);
        test_pair(10'd300, 10'd800, 0);
        test_pair(10'd1023, 10'd1023, 0);
        test_pair(10'd0, 10'd0, 0);
        test_rack_idle();
        test_join4();
        test_hold();
        test_release();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
